atsc_pad_core: RTL
==================

Name: atsc_pad_core

Overview:
- Transmit-side counterpart of the ATSC depad stage. Takes a stream of packed MPEG-TS bytes and emits fixed-length padded packets.
- Each 188-byte TS packet (47 words of 32 bits) is extended with pad words to a PADDED_WORDS-word frame, with tlast on the final word.
- Sits between the AXI wrapper m_axis_data port and s_axis_data port in the user-code area of a pad NoC block.
- Also reports a sync-byte check, a short-packet error, and a packet count.

Parameters:
PAYLOAD_WORDS, 47, payload words per TS packet (188 bytes / 4).
PADDED_WORDS, 64, total words per output frame (256 bytes); must be greater than PAYLOAD_WORDS.
PAD_WORD, 32'h00000000, value driven on each pad word.
SYNC_BYTE, 8'h47, expected first byte of each TS packet.

Ports:
clk  in  1  block clock; all logic is in this single domain.
reset  in  1  synchronous, active-high reset.
clear  in  1  synchronous, active-high; zeroes pkt_count only, no effect on datapath.
i_tdata  in  32  packed TS bytes; first byte is in [31:24].
i_tlast  in  1  early end-of-packet marker; otherwise ignored.
i_tvalid  in  1  input valid.
i_tready  out  1  input ready.
o_tdata  out  32  padded frame data.
o_tlast  out  1  asserted on word PADDED_WORDS-1 of each frame.
o_tvalid  out  1  output valid.
o_tready  in  1  output ready.
sync_err  out  1  one-cycle pulse: word 0 of a packet had [31:24] != SYNC_BYTE.
short_err  out  1  one-cycle pulse: i_tlast accepted before word PAYLOAD_WORDS-1.
pkt_count  out  32  number of complete frames emitted; wraps at 2^32.

Behaviour:
- Interface as decided: one clock, clk; reset is synchronous and active-high, named reset.
- Reset values: o_tvalid=0, o_tlast=0, o_tdata=0, sync_err=0, short_err=0, pkt_count=0, state=PASS, word_cnt=0.
- Output stage: one registered stage, so latency is 1 cycle from input accept to o_tvalid.
  - The register loads when o_tvalid=0 or o_tready=1 (load_en).
  - Throughput is 1 word/cycle under continuous ready.
  - o_tdata and o_tlast hold stable while o_tvalid=1 and o_tready=0.
- word_cnt: 0..PADDED_WORDS-1, advances on each load of a word into the output register.
- State PASS:
  - i_tready = load_en.
  - Accepted word is copied to o_tdata unchanged.
  - On word_cnt==0 accept: if i_tdata[31:24] != SYNC_BYTE, pulse sync_err on the next cycle. The data still passes unchanged.
  - Accept at word_cnt==PAYLOAD_WORDS-1 goes to PAD; i_tlast on that word is ignored.
  - Accept with i_tlast=1 and word_cnt<PAYLOAD_WORDS-1: pulse short_err, then go to PAD_SHORT.
- State PAD_SHORT:
  - i_tready=0.
  - On each load_en, emit PAD_WORD until word_cnt reaches PAYLOAD_WORDS-1, then go to PAD.
  - The frame length stays PADDED_WORDS.
- State PAD:
  - i_tready=0.
  - On each load_en, emit PAD_WORD.
  - At word_cnt==PADDED_WORDS-1, set o_tlast=1, reset word_cnt to 0, increment pkt_count, and go to PASS.
- No input is ever dropped or accepted during the PAD states.
- Back-pressure mid-frame freezes state and word_cnt.
- pkt_count:
  - Increments when the tlast word is loaded into the output register, not when it is handed off.
  - If clear and an increment coincide, clear wins (result 0).
- Reset mid-frame: the partial frame is discarded, o_tvalid drops the next cycle, and the next accepted word is treated as word 0.
- i_tvalid=0 in PASS: o_tvalid deasserts after the current word is taken. No pad is inserted on input starvation.

Test Plan:
- Packet pass-through: 47 words 0x47000001..0x4700002F with o_tready=1 → 64 output words; words 0-46 match the input, words 47-63 = 0x00000000; o_tlast only on word 63; pkt_count=1; no error pulses.
- Back-to-back throughput: 3 packets, continuous valid/ready → 192 output words in 192 cycles plus 1 of latency; i_tready low for exactly 17 cycles per frame; pkt_count=3.
- Sync error: word 0 = 0x12345678 → sync_err pulses once; frame is output intact with 64 words.
- Short packet: i_tlast on input word 9 → short_err pulse; output is 10 data words then 54 PAD_WORDs; o_tlast on word 63; the next input word starts a new frame.
- Random back-pressure: o_tready toggled pseudo-randomly, 5 packets → output identical to the uninterrupted case; o_tdata stable while stalled.
- Reset mid-frame plus clear: reset at output word 30, then 1 full packet → pkt_count=1, first output = new word 0; asserting clear together with the tlast load → pkt_count=0.

Source files
------------

// File: rtl/atsc_pad_core.sv
// Pads each 47-word MPEG-TS packet to a fixed PADDED_WORDS-word frame with tlast on the final word.
// One registered output stage (1-cycle latency); input is stalled during pad insertion and by o_tready.
module atsc_pad_core #(
  parameter int          PAYLOAD_WORDS = 47,
  parameter int          PADDED_WORDS  = 64,
  parameter logic [31:0] PAD_WORD      = 32'h0000_0000,
  parameter logic [7:0]  SYNC_BYTE     = 8'h47
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic [31:0] i_tdata,
  input  logic        i_tlast,
  input  logic        i_tvalid,
  output logic        i_tready,
  output logic [31:0] o_tdata,
  output logic        o_tlast,
  output logic        o_tvalid,
  input  logic        o_tready,
  output logic        sync_err,
  output logic        short_err,
  output logic [31:0] pkt_count
);

  localparam int CW = $clog2(PADDED_WORDS);
  localparam logic [CW-1:0] LAST_PAYLOAD = CW'(PAYLOAD_WORDS - 1);
  localparam logic [CW-1:0] LAST_WORD    = CW'(PADDED_WORDS - 1);

  typedef enum logic [1:0] {
    ST_PASS      = 2'd0,
    ST_PAD_SHORT = 2'd1,
    ST_PAD       = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] word_cnt_q, word_cnt_d;
  logic [31:0]   o_tdata_q, o_tdata_d;
  logic          o_tlast_q, o_tlast_d;
  logic          o_tvalid_q, o_tvalid_d;
  logic          sync_err_q, sync_err_d;
  logic          short_err_q, short_err_d;
  logic [31:0]   pkt_count_q, pkt_count_d;

  logic load_en;
  logic accept;
  logic pad_load;
  logic frame_end;

  assign load_en   = !o_tvalid_q || o_tready;
  assign accept    = i_tvalid && i_tready;
  assign pad_load  = load_en && (state_q != ST_PASS);
  assign frame_end = pad_load && (state_q == ST_PAD) && (word_cnt_q == LAST_WORD);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_PASS;
      word_cnt_q  <= '0;
      o_tdata_q   <= '0;
      o_tlast_q   <= 1'b0;
      o_tvalid_q  <= 1'b0;
      sync_err_q  <= 1'b0;
      short_err_q <= 1'b0;
      pkt_count_q <= '0;
    end else begin
      state_q     <= state_d;
      word_cnt_q  <= word_cnt_d;
      o_tdata_q   <= o_tdata_d;
      o_tlast_q   <= o_tlast_d;
      o_tvalid_q  <= o_tvalid_d;
      sync_err_q  <= sync_err_d;
      short_err_q <= short_err_d;
      pkt_count_q <= pkt_count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_PASS: begin
        if (accept) begin
          // A tlast on the final payload word is a normal end, not a short packet.
          if (word_cnt_q == LAST_PAYLOAD) begin
            state_d = ST_PAD;
          end else if (i_tlast) begin
            state_d = ST_PAD_SHORT;
          end
        end
      end
      ST_PAD_SHORT: begin
        if (load_en && (word_cnt_q == LAST_PAYLOAD)) begin
          state_d = ST_PAD;
        end
      end
      ST_PAD: begin
        if (frame_end) begin
          state_d = ST_PASS;
        end
      end
      default: state_d = ST_PASS;
    endcase
  end

  always_comb begin
    i_tready = 1'b0;
    if (state_q == ST_PASS) begin
      i_tready = load_en;
    end
  end

  always_comb begin
    word_cnt_d  = word_cnt_q;
    o_tdata_d   = o_tdata_q;
    o_tlast_d   = o_tlast_q;
    o_tvalid_d  = o_tvalid_q;
    sync_err_d  = 1'b0;
    short_err_d = 1'b0;
    if (accept) begin
      o_tvalid_d  = 1'b1;
      o_tdata_d   = i_tdata;
      o_tlast_d   = 1'b0;
      word_cnt_d  = word_cnt_q + CW'(1);
      sync_err_d  = (word_cnt_q == '0) && (i_tdata[31:24] != SYNC_BYTE);
      short_err_d = i_tlast && (word_cnt_q < LAST_PAYLOAD);
    end else if (pad_load) begin
      o_tvalid_d = 1'b1;
      o_tdata_d  = PAD_WORD;
      o_tlast_d  = frame_end;
      word_cnt_d = frame_end ? '0 : word_cnt_q + CW'(1);
    end else if (load_en) begin
      // Starved input: drain the register rather than inventing pad words.
      o_tvalid_d = 1'b0;
    end
  end

  always_comb begin
    pkt_count_d = pkt_count_q;
    if (clear) begin
      pkt_count_d = '0;
    end else if (frame_end) begin
      pkt_count_d = pkt_count_q + 32'd1;
    end
  end

  assign o_tdata   = o_tdata_q;
  assign o_tlast   = o_tlast_q;
  assign o_tvalid  = o_tvalid_q;
  assign sync_err  = sync_err_q;
  assign short_err = short_err_q;
  assign pkt_count = pkt_count_q;

endmodule
